// File: rtl/imem_port_arbiter_if.sv
// Signal bundle for the instruction-memory port arbiter: the fetch port,
// the debug/loader read port and the shared instruction-memory port.
interface imem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_stall;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    // Environment side: the fetch stage, the debug requester and the memory.
    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, mem_data,
        input  if_data, if_stall, dbg_ack, dbg_data, mem_ce, mem_addr
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, mem_data,
        output if_data, if_stall, dbg_ack, dbg_data, mem_ce, mem_addr
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one single-ported instruction memory between the fetch stage and a
// debug/loader read port. Fetch normally owns the port; a pending debug read
// steals exactly one cycle, either immediately when fetch is idle or after at
// most DBG_MAXWAIT cycles of waiting behind a busy fetch stage.
module imem_port_arbiter #(
    parameter int DBG_MAXWAIT = 4    // legal range 1..15
) (
    input  logic               clk,
    input  logic               rst,  // asynchronous, active-low
    imem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_IF  = 2'd0;   // fetch owns the port
    localparam logic [1:0] S_DBG = 2'd1;   // single debug access cycle
    localparam logic [1:0] S_ACK = 2'd2;   // debug acknowledged, fetch owns the port

    // Value of wait_cnt at which a waiting debug request is forced through.
    localparam logic [3:0] WAIT_LAST = 4'(DBG_MAXWAIT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;

    // Next-state and starvation counter: fetch wins ties until the debug
    // request has waited WAIT_LAST cycles; an idle fetch grants debug at once.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IF: begin
                if (!bus.dbg_req) begin
                    wait_cnt_nxt = 4'd0;
                end else if (!bus.if_req || (wait_cnt == WAIT_LAST)) begin
                    state_nxt    = S_DBG;
                    wait_cnt_nxt = 4'd0;
                end else if (wait_cnt != 4'hF) begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_DBG: begin
                state_nxt    = S_ACK;
                wait_cnt_nxt = 4'd0;
            end
            S_ACK: begin
                state_nxt    = S_IF;
                wait_cnt_nxt = 4'd0;
            end
            default: begin
                state_nxt    = S_IF;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State and counter registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Capture debug read data at the end of the access cycle and pulse the
    // acknowledge for the following cycle (which is exactly S_ACK).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dbg_ack  <= 1'b0;
            bus.dbg_data <= 32'h0;
        end else begin
            bus.dbg_ack <= (state == S_DBG);
            if (state == S_DBG) begin
                bus.dbg_data <= bus.mem_data;
            end
        end
    end

    // Port steering: debug drives the memory only in S_DBG, where a requesting
    // fetch is stalled and receives no data; addresses pass through untouched.
    always_comb begin
        bus.mem_ce   = bus.if_req;
        bus.mem_addr = bus.if_addr;
        bus.if_data  = bus.mem_data;
        bus.if_stall = 1'b0;
        if (state == S_DBG) begin
            bus.mem_ce   = 1'b1;
            bus.mem_addr = bus.dbg_addr;
            bus.if_data  = 32'h0;
            bus.if_stall = bus.if_req;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter with a small ROM model behind the
// memory port. Each scenario task drives its own vectors and checks inline.
module tb_imem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] rom [0:1023];
    logic [31:0] fetchWords [0:3];

    imem_port_arbiter_if bus();

    imem_port_arbiter #(.DBG_MAXWAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Combinational ROM; a disabled memory returns zero.
    assign bus.mem_data = bus.mem_ce ? rom[bus.mem_addr[11:2]] : 32'h0;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    // Advance to just after the next rising edge.
    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dbg_req = 1'b0; bus.dbg_addr = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.dbg_ack); end
        checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", bus.dbg_data); end
        checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce: got %b expected 0", bus.mem_ce); end
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.if_stall); end
        nextCycle();
        rst = 1'b1;
    endtask

    task automatic test_fetch_only;
        for (int i = 0; i < 4; i++) begin
            bus.if_req = 1'b1; bus.if_addr = 32'(i * 4); bus.dbg_req = 1'b0;
            #3;
            checks++; if (bus.if_data !== fetchWords[i]) begin errors++; $display("[TB] FAIL fetch_data[%0d]: got %h expected %h", i, bus.if_data, fetchWords[i]); end
            checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall[%0d]: got %b expected 0", i, bus.if_stall); end
            checks++; if (bus.mem_ce !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ce[%0d]: got %b expected 1", i, bus.mem_ce); end
            checks++; if (bus.mem_addr !== 32'(i * 4)) begin errors++; $display("[TB] FAIL fetch_addr[%0d]: got %h expected %h", i, bus.mem_addr, 32'(i * 4)); end
            nextCycle();
        end
    endtask

    task automatic test_disabled;
        bus.if_req = 1'b0; bus.if_addr = 32'h8; bus.dbg_req = 1'b0;
        #3;
        checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("[TB] FAIL disabled_ce: got %b expected 0", bus.mem_ce); end
        checks++; if (bus.if_data !== 32'h0) begin errors++; $display("[TB] FAIL disabled_data: got %h expected 00000000", bus.if_data); end
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("[TB] FAIL disabled_stall: got %b expected 0", bus.if_stall); end
        nextCycle();
    endtask

    task automatic test_idle_debug;
        // cycle 0: request raised, port still with (idle) fetch
        bus.if_req = 1'b0; bus.dbg_req = 1'b1; bus.dbg_addr = 32'h10;
        #3;
        checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("[TB] FAIL idle_c0_ce: got %b expected 0", bus.mem_ce); end
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_c0_ack: got %b expected 0", bus.dbg_ack); end
        nextCycle();
        // cycle 1: debug access
        #3;
        checks++; if (bus.mem_ce !== 1'b1) begin errors++; $display("[TB] FAIL idle_c1_ce: got %b expected 1", bus.mem_ce); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL idle_c1_addr: got %h expected 00000010", bus.mem_addr); end
        checks++; if (bus.if_data !== 32'h0) begin errors++; $display("[TB] FAIL idle_c1_ifdata: got %h expected 00000000", bus.if_data); end
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("[TB] FAIL idle_c1_stall: got %b expected 0", bus.if_stall); end
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_c1_ack: got %b expected 0", bus.dbg_ack); end
        nextCycle();
        // cycle 2: acknowledge
        bus.dbg_req = 1'b0;
        #3;
        checks++; if (bus.dbg_ack !== 1'b1) begin errors++; $display("[TB] FAIL idle_c2_ack: got %b expected 1", bus.dbg_ack); end
        checks++; if (bus.dbg_data !== 32'h00222820) begin errors++; $display("[TB] FAIL idle_c2_data: got %h expected 00222820", bus.dbg_data); end
        nextCycle();
        // cycle 3: pulse over, data held
        #3;
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_c3_ack: got %b expected 0", bus.dbg_ack); end
        checks++; if (bus.dbg_data !== 32'h00222820) begin errors++; $display("[TB] FAIL idle_c3_data: got %h expected 00222820", bus.dbg_data); end
        nextCycle();
    endtask

    task automatic test_starvation;
        logic [31:0] expData;
        logic [31:0] expAddr;
        logic [31:0] expDbg;
        for (int c = 0; c < 7; c++) begin
            bus.if_req   = 1'b1;
            bus.if_addr  = 32'((c % 4) * 4);
            bus.dbg_req  = (c < 5);
            bus.dbg_addr = 32'h0C;
            expData = (c == 4) ? 32'h0 : fetchWords[c % 4];
            expAddr = (c == 4) ? 32'h0C : 32'((c % 4) * 4);
            expDbg  = (c >= 5) ? 32'h3404ffff : 32'h00222820;
            #3;
            checks++; if (bus.if_stall !== (c == 4)) begin errors++; $display("[TB] FAIL starve_stall[%0d]: got %b expected %b", c, bus.if_stall, (c == 4)); end
            checks++; if (bus.dbg_ack !== (c == 5)) begin errors++; $display("[TB] FAIL starve_ack[%0d]: got %b expected %b", c, bus.dbg_ack, (c == 5)); end
            checks++; if (bus.if_data !== expData) begin errors++; $display("[TB] FAIL starve_ifdata[%0d]: got %h expected %h", c, bus.if_data, expData); end
            checks++; if (bus.mem_addr !== expAddr) begin errors++; $display("[TB] FAIL starve_addr[%0d]: got %h expected %h", c, bus.mem_addr, expAddr); end
            checks++; if (bus.dbg_data !== expDbg) begin errors++; $display("[TB] FAIL starve_dbgdata[%0d]: got %h expected %h", c, bus.dbg_data, expDbg); end
            nextCycle();
        end
        bus.if_req = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        bus.if_req = 1'b0; bus.dbg_req = 1'b1; bus.dbg_addr = 32'h4;
        nextCycle();
        // now in the debug access cycle
        #1;
        checks++; if (bus.mem_addr !== 32'h4) begin errors++; $display("[TB] FAIL rstmid_dbg_addr: got %h expected 00000004", bus.mem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ce: got %b expected 0", bus.mem_ce); end
        checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_data: got %h expected 00000000", bus.dbg_data); end
        nextCycle();
        #3;
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ack: got %b expected 0", bus.dbg_ack); end
        nextCycle();
        rst = 1'b1;
        bus.dbg_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h8;
        #3;
        checks++; if (bus.if_data !== 32'h3403ff00) begin errors++; $display("[TB] FAIL rstmid_release_data: got %h expected 3403ff00", bus.if_data); end
        checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_release_stall: got %b expected 0", bus.if_stall); end
        nextCycle();
        #3;
        checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_noack: got %b expected 0", bus.dbg_ack); end
        checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_nodata: got %h expected 00000000", bus.dbg_data); end
        nextCycle();
        bus.if_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic expCe;
        logic expAck;
        for (int c = 0; c < 7; c++) begin
            bus.if_req   = 1'b0;
            bus.dbg_req  = (c < 5);
            bus.dbg_addr = (c < 2) ? 32'h10 : 32'h8;
            expCe  = (c == 1) || (c == 4);
            expAck = (c == 2) || (c == 5);
            #3;
            checks++; if (bus.mem_ce !== expCe) begin errors++; $display("[TB] FAIL b2b_ce[%0d]: got %b expected %b", c, bus.mem_ce, expCe); end
            checks++; if (bus.dbg_ack !== expAck) begin errors++; $display("[TB] FAIL b2b_ack[%0d]: got %b expected %b", c, bus.dbg_ack, expAck); end
            if (c == 2) begin
                checks++; if (bus.dbg_data !== 32'h00222820) begin errors++; $display("[TB] FAIL b2b_data1: got %h expected 00222820", bus.dbg_data); end
            end
            if (c == 5) begin
                checks++; if (bus.dbg_data !== 32'h3403ff00) begin errors++; $display("[TB] FAIL b2b_data2: got %h expected 3403ff00", bus.dbg_data); end
            end
            nextCycle();
        end
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        rom[0] = 32'h34011100;
        rom[1] = 32'h34020020;
        rom[2] = 32'h3403ff00;
        rom[3] = 32'h3404ffff;
        rom[4] = 32'h00222820;
        for (int i = 0; i < 4; i++) fetchWords[i] = rom[i];

        test_reset();
        test_fetch_only();
        test_disabled();
        test_idle_debug();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 SHALL have parameter DBG_MAXWAIT, default 4, meaning the maximum number of consecutive cycles a pending debug request waits while fetch holds the port (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port if_req  input  1  fetch stage requests an instruction this cycle.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_data  output  32  instruction returned to fetch, valid in the same cycle.
REQ-007 SHALL have port if_stall  output  1  fetch must hold PC; the port is lent to debug.
REQ-008 SHALL have port dbg_req  input  1  debug/loader read request; level, held until dbg_ack.
REQ-009 SHALL have port dbg_addr  input  32  debug byte address; stable while dbg_req=1.
REQ-010 SHALL have port dbg_ack  output  1  registered one-cycle pulse; dbg_data is valid.
REQ-011 SHALL have port dbg_data  output  32  registered debug read result; holds until the next access.
REQ-012 SHALL have port mem_ce  output  1  chip enable to instruction memory (1 = enabled).
REQ-013 SHALL have port mem_addr  output  32  address to instruction memory (word index = addr[11:2]).
REQ-014 SHALL have port mem_data  input  32  combinational read data from instruction memory.

Function
REQ-015 SHALL implement a three-state FSM: S_IF (fetch owns the port), S_DBG (one debug access cycle), S_ACK (acknowledge cycle; fetch owns the port).
REQ-016 In S_IF and S_ACK: mem_ce=if_req, mem_addr=if_addr, if_data=mem_data, if_stall=0.
REQ-017 In S_DBG: mem_ce=1, mem_addr=dbg_addr, if_data=0, if_stall=if_req.
REQ-018 In S_IF with dbg_req=0, the FSM SHALL stay in S_IF and clear wait_cnt to 0.
REQ-019 In S_IF with dbg_req=1 and if_req=0, the FSM SHALL go to S_DBG next cycle; there is no fetch to starve.
REQ-020 In S_IF with dbg_req=1 and if_req=1: if wait_cnt=DBG_MAXWAIT-1, the FSM SHALL go to S_DBG; otherwise it SHALL stay in S_IF and increment wait_cnt.
REQ-021 wait_cnt SHALL be 4 bits, SHALL saturate (never wrap), and SHALL clear on entry to S_DBG.
REQ-022 S_DBG SHALL last exactly one cycle; at its closing edge dbg_data<=mem_data and the FSM SHALL move to S_ACK.
REQ-023 dbg_ack SHALL equal 1 only in S_ACK; S_ACK SHALL go to S_IF unconditionally, and dbg_req SHALL be ignored in S_ACK.
REQ-024 Worst-case debug latency from dbg_req rise to dbg_ack SHALL be DBG_MAXWAIT+1 cycles; the best case SHALL be 2 cycles.
REQ-025 A stalled fetch SHALL lose exactly one cycle per debug access; no fetch data SHALL be delivered while if_stall=1.
REQ-026 The block SHALL pass addresses unmodified; misaligned addresses SHALL be neither checked nor altered.
REQ-027 Simultaneous if_req and dbg_req rising in S_IF with wait_cnt=0 SHALL grant fetch first.

Reset
REQ-028 While rst=0 (asynchronous): state=S_IF, wait_cnt=0, dbg_ack=0, dbg_data=0.
REQ-029 Reset asserted during S_DBG SHALL abort the access: no dbg_ack and no dbg_data update; the requester retries after reset.
REQ-030 After reset release, outputs SHALL follow REQ-016 from the first cycle.

Verification
REQ-031 Fetch only: if_req=1 with if_addr=0,4,8,12 on consecutive cycles -> if_data=34011100,34020020,3403ff00,3404ffff in the same cycles; if_stall=0 throughout.
REQ-032 Idle-port debug read: if_req=0, dbg_req=1, dbg_addr=0x10 -> S_DBG next cycle; dbg_ack=1 two cycles after request; dbg_data=00222820.
REQ-033 Starvation bound: if_req=1 held, dbg_req=1 at cycle 0 with DBG_MAXWAIT=4 -> if_stall=1 only at cycle 4; dbg_ack=1 at cycle 5; fetch resumes at cycle 5.
REQ-034 Disabled fetch: if_req=0, dbg_req=0 -> mem_ce=0 and if_data=0.
REQ-035 Reset mid-access: rst=0 during S_DBG -> dbg_ack stays 0, dbg_data=0, and state is S_IF after release.
REQ-036 Back-to-back debug: dbg_req held high through dbg_ack -> S_ACK ignores the request; the second grant occurs no earlier than 2 cycles after the first dbg_ack.
